complex_rotator_pipe: RTL and testbench
=======================================

COMPLEX_ROTATOR_PIPE -- requirements
Module: complex_rotator_pipe

Interface
REQ-001 Parameter DATA_W, default 8, signed integer width of in_r/in_i.
REQ-002 Parameter COEF_W, default 12, signed width of cos_c/sin_c.
REQ-003 Parameter COEF_FRAC, default 10, fractional bits of cos_c/sin_c; legal range 1..COEF_W-1.
REQ-004 Parameter OUT_W, default 13, signed integer width of out_r/out_i.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  input sample and coefficient present.
REQ-008 in_ready  output  1  block accepts input this cycle.
REQ-009 in_r, in_i  input  DATA_W each  signed real/imag sample.
REQ-010 cos_c, sin_c  input  COEF_W each  signed twiddle, Q(COEF_W-COEF_FRAC).COEF_FRAC.
REQ-011 conj  input  1  1 = multiply by conjugate twiddle (cos - j sin), for the inverse transform.
REQ-012 out_valid  output  1  out_r/out_i/sat valid.
REQ-013 out_ready  input  1  downstream accepts output this cycle.
REQ-014 out_r, out_i  output  OUT_W each  signed rotated sample.
REQ-015 sat  output  1  1 = out_r or out_i clipped on this output beat.

Function
REQ-016 Transfer SHALL occur at input when in_valid && in_ready, at output when out_valid && out_ready.
REQ-017 Datapath SHALL be 3 stages: S1 register operands and conj; S2 four full-precision signed products (DATA_W+COEF_W bits); S3 sums (one extra bit), rounding, saturation.
REQ-018 Pipeline advance enable en = !out_valid || out_ready; in_ready SHALL equal en combinationally; all stages hold when en = 0.
REQ-019 Each stage SHALL carry a valid bit; bubbles propagate when en = 1 and in_valid = 0.
REQ-020 Latency SHALL be 3 cycles from accepted input to out_valid with out_ready held high; throughput one sample per cycle.
REQ-021 Normal: re = cos*in_r - sin*in_i, im = cos*in_i + sin*in_r; conj: sin negated in both terms (re = cos*in_r + sin*in_i, im = cos*in_i - sin*in_r).
REQ-022 Negation SHALL be applied to the product, not the coefficient, so sin = -2^(COEF_W-1) produces no overflow.
REQ-023 Rounding: add 2^(COEF_FRAC-1), arithmetic shift right COEF_FRAC (round half toward +infinity).
REQ-024 Saturation: rounded values outside [-2^(OUT_W-1), 2^(OUT_W-1)-1] clip to nearest bound; sat = 1 if either component clipped.
REQ-025 out_r/out_i/sat SHALL remain stable while out_valid && !out_ready.
REQ-026 No input SHALL be dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-027 rst = 1 SHALL immediately clear all stage valid bits; out_valid = 0, out_r = 0, out_i = 0, sat = 0.
REQ-028 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-029 Reset mid-operation SHALL discard all in-flight samples; first output after release derives from first post-release accepted input.

Verification
REQ-030 Defaults, in=(100,0), cos=1024, sin=0, conj=0, out_ready=1 -> 3 cycles later out=(100,0), sat=0.
REQ-031 Rounding: in=(3,0), cos=512, sin=0 -> out_r=2; in=(-3,0) -> out_r=-1.
REQ-032 Conj: in=(0,10), cos=0, sin=1024 -> conj=0 gives (-10,0); conj=1 gives (10,0).
REQ-033 OUT_W=9, in=(-128,-128), cos=2047, sin=-2048 -> out_r=-256, sat=1; defaults same input -> out_r=-512, sat=0.
REQ-034 Stream 8 samples, out_ready toggling 1,0,0,1,...: all 8 outputs in order, held stable while stalled, in_ready low only when out_valid && !out_ready.
REQ-035 Assert rst with 2 samples in flight -> out_valid=0 immediately, no stale output after release.

Source files
------------

// File: rtl/complex_rotator_pipe.sv
// rtl/complex_rotator_pipe.sv - three-stage complex rotator (sample x twiddle) with rounding and saturation
//
// Purpose: multiplies a complex sample by a fixed-point twiddle (or its conjugate),
//          rounds away the coefficient fraction and clips to the output width.
//          Stages: S1 operand register, S2 four full-precision products,
//          S3 sums, rounding, saturation and the output register.
// Ports:
//    clk, rst            clock, asynchronous active-high reset
//    in_valid/in_ready   input handshake
//    in_r, in_i          signed sample, DATA_W bits each
//    cos_c, sin_c        signed twiddle, COEF_FRAC fractional bits
//    conj                1 = rotate by the conjugate twiddle
//    out_valid/out_ready output handshake
//    out_r, out_i        signed rotated sample, OUT_W bits each
//    sat                 either output component was clipped on this beat
module complex_rotator_pipe #(
   parameter int DATA_W    = 8,
   parameter int COEF_W    = 12,
   parameter int COEF_FRAC = 10,
   parameter int OUT_W     = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_r,
   input  logic [DATA_W-1:0] in_i,
   input  logic [COEF_W-1:0] cos_c,
   input  logic [COEF_W-1:0] sin_c,
   input  logic              conj,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_r,
   output logic [OUT_W-1:0]  out_i,
   output logic              sat
);

   localparam int PW = DATA_W + COEF_W;   // full product width
   localparam int SW = PW + 1;            // sum width, one growth bit
   localparam int WW = SW + OUT_W;        // wide enough to compare against any output bound

   localparam logic signed [SW-1:0] RND  = SW'(1) <<< (COEF_FRAC - 1);
   localparam logic signed [WW-1:0] ONE  = WW'(1);
   localparam logic signed [WW-1:0] MAXV = (ONE <<< (OUT_W - 1)) - ONE;
   localparam logic signed [WW-1:0] MINV = -MAXV - ONE;

   // The whole pipeline moves together; it only stops when the output beat is stuck.
   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // ---------------- S1: operand register ----------------
   logic                     v1, cj1;
   logic signed [DATA_W-1:0] r1, i1;
   logic signed [COEF_W-1:0] c1, s1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1  <= 1'b0;
         cj1 <= 1'b0;
         r1  <= '0;
         i1  <= '0;
         c1  <= '0;
         s1  <= '0;
      end else if (en) begin
         v1  <= in_valid;
         cj1 <= conj;
         r1  <= in_r;
         i1  <= in_i;
         c1  <= cos_c;
         s1  <= sin_c;
      end
   end

   // ---------------- S2: full-precision products ----------------
   logic signed [PW-1:0] r1x, i1x, c1x, s1x;
   assign r1x = {{COEF_W{r1[DATA_W-1]}}, r1};
   assign i1x = {{COEF_W{i1[DATA_W-1]}}, i1};
   assign c1x = {{DATA_W{c1[COEF_W-1]}}, c1};
   assign s1x = {{DATA_W{s1[COEF_W-1]}}, s1};

   logic                 v2, cj2;
   logic signed [PW-1:0] p_cr, p_si, p_ci, p_sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2   <= 1'b0;
         cj2  <= 1'b0;
         p_cr <= '0;
         p_si <= '0;
         p_ci <= '0;
         p_sr <= '0;
      end else if (en) begin
         v2   <= v1;
         cj2  <= cj1;
         p_cr <= c1x * r1x;
         p_si <= s1x * i1x;
         p_ci <= c1x * i1x;
         p_sr <= s1x * r1x;
      end
   end

   // ---------------- S3: sums, rounding, saturation ----------------
   // Conjugation flips the sign of the sin products rather than the sin
   // coefficient, so the most negative sin value needs no extra range.
   logic signed [SW-1:0] cr_e, si_e, ci_e, sr_e;
   logic signed [SW-1:0] re_sum, im_sum, re_rnd, im_rnd, re_sh, im_sh;
   logic signed [WW-1:0] re_ext, im_ext;
   logic        [OUT_W:0] re_c, im_c;

   function automatic logic [OUT_W:0] clip(input logic signed [WW-1:0] v);
      // returns {clipped_flag, value}
      if (v > MAXV)
         return {1'b1, MAXV[OUT_W-1:0]};
      else if (v < MINV)
         return {1'b1, MINV[OUT_W-1:0]};
      else
         return {1'b0, v[OUT_W-1:0]};
   endfunction

   always_comb begin
      cr_e   = {p_cr[PW-1], p_cr};
      si_e   = {p_si[PW-1], p_si};
      ci_e   = {p_ci[PW-1], p_ci};
      sr_e   = {p_sr[PW-1], p_sr};
      re_sum = cj2 ? (cr_e + si_e) : (cr_e - si_e);
      im_sum = cj2 ? (ci_e - sr_e) : (ci_e + sr_e);
      // adding half an LSB then flooring rounds ties toward +infinity
      re_rnd = re_sum + RND;
      im_rnd = im_sum + RND;
      re_sh  = re_rnd >>> COEF_FRAC;
      im_sh  = im_rnd >>> COEF_FRAC;
      re_ext = {{OUT_W{re_sh[SW-1]}}, re_sh};
      im_ext = {{OUT_W{im_sh[SW-1]}}, im_sh};
      re_c   = clip(re_ext);
      im_c   = clip(im_ext);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_r     <= '0;
         out_i     <= '0;
         sat       <= 1'b0;
      end else if (en) begin
         out_valid <= v2;
         if (v2) begin
            out_r <= re_c[OUT_W-1:0];
            out_i <= im_c[OUT_W-1:0];
            sat   <= re_c[OUT_W] | im_c[OUT_W];
         end
      end
   end

endmodule

// File: tb/tb_complex_rotator_pipe.sv
// tb/tb_complex_rotator_pipe.sv - directed self-checking bench for complex_rotator_pipe
module tb_complex_rotator_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready, conj;
   logic [7:0]  in_r, in_i;
   logic [11:0] cos_c, sin_c;

   logic        in_ready, out_valid, sat;
   logic [12:0] out_r, out_i;

   logic        in_ready9, out_valid9, sat9;
   logic [8:0]  out_r9, out_i9;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   complex_rotator_pipe dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_r(in_r), .in_i(in_i), .cos_c(cos_c), .sin_c(sin_c), .conj(conj),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_r(out_r), .out_i(out_i), .sat(sat)
   );

   complex_rotator_pipe #(.OUT_W(9)) dut9 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready9),
      .in_r(in_r), .in_i(in_i), .cos_c(cos_c), .sin_c(sin_c), .conj(conj),
      .out_valid(out_valid9), .out_ready(out_ready),
      .out_r(out_r9), .out_i(out_i9), .sat(sat9)
   );

   task automatic chk(input string tag, input integer obs, input integer exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int r, input int i, input int c, input int s, input logic cj);
      in_r  = 8'(r);
      in_i  = 8'(i);
      cos_c = 12'(c);
      sin_c = 12'(s);
      conj  = cj;
   endtask

   // Called at a negedge with out_ready = 1: sends one sample and checks the
   // 3-cycle latency, the result, and that exactly one beat comes out.
   task automatic single(input string tag, input int r, input int i, input int c, input int s,
                         input logic cj, input int er, input int ei, input int es);
      drive(r, i, c, s, cj);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_lat1"}, out_valid, 0);
      @(negedge clk);
      chk({tag, "_lat2"}, out_valid, 0);
      @(negedge clk);
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_re"}, $signed(out_r), er);
      chk({tag, "_im"}, $signed(out_i), ei);
      chk({tag, "_sat"}, sat, es);
      @(negedge clk);
      chk({tag, "_single_beat"}, out_valid, 0);
   endtask

   initial begin
      int sent;
      int recv;

      // ---- reset state ----
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive(0, 0, 0, 0, 1'b0);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_r", $signed(out_r), 0);
      chk("rst_out_i", $signed(out_i), 0);
      chk("rst_sat", sat, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready_held", in_ready, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);

      // ---- basic function, rounding, conjugate ----
      single("unity",     100,   0, 1024,    0, 1'b0,  100,   0, 0);
      single("round_pos",   3,   0,  512,    0, 1'b0,    2,   0, 0);
      single("round_neg",  -3,   0,  512,    0, 1'b0,   -1,   0, 0);
      single("rot_norm",    0,  10,    0, 1024, 1'b0,  -10,   0, 0);
      single("rot_conj",    0,  10,    0, 1024, 1'b1,   10,   0, 0);
      single("minsin_conj", 0, -128,   0, -2048, 1'b1, 256,   0, 0);

      // ---- saturation: narrow instance clips, default instance does not ----
      drive(-128, -128, 2047, -2048, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("neg_w9_valid", out_valid9, 1);
      chk("neg_w9_re", $signed(out_r9), -256);
      chk("neg_w9_im", $signed(out_i9), 0);
      chk("neg_w9_sat", sat9, 1);
      chk("neg_w13_re", $signed(out_r), -512);
      chk("neg_w13_sat", sat, 0);
      @(negedge clk);

      drive(127, 127, 2047, -2048, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pos_w9_re", $signed(out_r9), 255);
      chk("pos_w9_sat", sat9, 1);
      chk("pos_w13_re", $signed(out_r), 508);
      chk("pos_w13_im", $signed(out_i), 0);
      chk("pos_w13_sat", sat, 0);
      @(negedge clk);

      // ---- stream of 8 with out_ready pattern 1,0,0,1 ----
      // 90-degree rotation: (r, i) -> (-i, r); sample k is (10k+1, -(5k+3))
      sent = 0;
      recv = 0;
      for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
         @(negedge clk);
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         if (sent < 8) begin
            drive(10 * sent + 1, -(5 * sent + 3), 0, 1024, 1'b0);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         chk("stream_in_ready", in_ready, (out_valid === 1'b1 && out_ready == 1'b0) ? 0 : 1);
         if (out_valid === 1'b1) begin
            // while stalled the same beat must stay on the output
            chk("stream_re", $signed(out_r), 5 * recv + 3);
            chk("stream_im", $signed(out_i), 10 * recv + 1);
            chk("stream_sat", sat, 0);
            if (out_ready) recv++;
         end
         if (in_valid && in_ready) sent++;
      end
      chk("stream_count", recv, 8);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("stream_no_extra", out_valid, 0);

      // ---- reset with samples in flight ----
      for (int k = 0; k < 3; k++) begin
         drive(7 + k, 7 + k, 1024, 0, 1'b0);
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("flight_valid", out_valid, 1);
      chk("flight_re", $signed(out_r), 7);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_r", $signed(out_r), 0);
      chk("midrst_sat", sat, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("no_stale", out_valid, 0);
      end
      single("after_rst", 20, -20, 1024, 0, 1'b0, 20, -20, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
